// File: rtl/scan_sequencer.sv
// scan_sequencer: drives the select code and enable of the downstream 4-to-16
// decoder. It walks a programmable window of channels [first..last] in either
// direction (modulo 2^SEL_W) and holds each channel for dwell+1 cycles. A scan
// is either one-shot (ends with a done pulse) or continuous (restarts at first
// with a wrap pulse). It can be aborted with stop.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, highest priority
//   start     begin a scan (sampled only while idle)
//   stop      abort a scan (beats start while idle, beats step/wrap while running)
//   dir       0 = step +1, 1 = step -1, latched on start
//   one_shot  1 = finish at last, 0 = restart at first, latched on start
//   first     start channel, latched on start
//   last      end channel, latched on start
//   dwell     per-channel hold minus one, latched on start
//   sel       current channel, to decoder `in`
//   sel_en    channel valid, to decoder `en`
//   busy      high while scanning
//   done      one-cycle pulse at the end of a one-shot scan
//   wrap      one-cycle pulse when a continuous scan restarts at first
module scan_sequencer #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               one_shot,
  input  logic [SEL_W-1:0]   first,
  input  logic [SEL_W-1:0]   last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Scan parameters captured at start so the window cannot change mid-scan.
  logic               dir_q, dir_d;
  logic               one_shot_q, one_shot_d;
  logic [SEL_W-1:0]   first_q, first_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic sel_en_q, sel_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic wrap_q, wrap_d;

  logic [SEL_W-1:0] sel_step;

  // Natural SEL_W-bit truncation gives the modulo wrap in both directions.
  assign sel_step = dir_q ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    one_shot_d = one_shot_q;
    first_d    = first_q;
    last_d     = last_q;
    dwell_d    = dwell_q;
    sel_en_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wrap_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          dir_d      = dir;
          one_shot_d = one_shot;
          first_d    = first;
          last_d     = last;
          dwell_d    = dwell;
          sel_d      = first;
          cnt_d      = dwell;
          state_d    = StRun;
          sel_en_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d    = cnt_q - DWELL_W'(1);
          sel_en_d = 1'b1;
          busy_d   = 1'b1;
        end else if (sel_q != last_q) begin
          sel_d    = sel_step;
          cnt_d    = dwell_q;
          sel_en_d = 1'b1;
          busy_d   = 1'b1;
        end else if (one_shot_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          sel_d    = first_q;
          cnt_d    = dwell_q;
          sel_en_d = 1'b1;
          busy_d   = 1'b1;
          wrap_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      first_q    <= '0;
      last_q     <= '0;
      dwell_q    <= '0;
      sel_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      one_shot_q <= one_shot_d;
      first_q    <= first_d;
      last_q     <= last_d;
      dwell_q    <= dwell_d;
      sel_en_q   <= sel_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule
